// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS controller:
//   - opcode constants for the supported instruction subset
//   - ctrl_state_t, the controller state encoding
//   - encodings of the alu_op, alu_src_b and pc_src datapath selects
//   - is_zero_ext(), which picks zero- vs sign-extension for an opcode
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTEXEC,
    S_RTWB,
    S_IEXEC,
    S_IWB,
    S_BRANCH,
    S_JUMP,
    S_ILLEGAL
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2,
    ALU_LOGIC = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pc_src_t;

  // Logical immediates (andi, ori) are zero-extended; everything else that
  // uses the immediate treats it as signed.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mips_ctrl_decode
// Purely combinational output decoder: maps the controller state plus the
// current instruction opcode onto the datapath enables and mux selects.
//
// Ports:
//   i_state      controller state (ctrl_state_t encoding)
//   i_opcode     opcode of the instruction in flight (live in DECODE,
//                latched copy afterwards)
//   i_mem_ready  memory handshake, qualifies the FETCH enables
//   i_alu_zero   ALU zero flag, gates the branch PC write
//   o_*          datapath controls, same meaning as the top-level outputs
// -----------------------------------------------------------------------------
module mips_ctrl_decode
  import mips_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic [OPC_W-1:0]   i_opcode,
  input  logic               i_mem_ready,
  input  logic               i_alu_zero,
  output logic               o_pc_write,
  output logic               o_ir_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_i_or_d,
  output logic               o_reg_write,
  output logic               o_reg_dst,
  output logic               o_mem_to_reg,
  output logic               o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [1:0]         o_alu_op,
  output logic               o_ext_zero,
  output logic [1:0]         o_pc_src,
  output logic               o_illegal_op
);

  ctrl_state_t w_state;
  assign w_state = ctrl_state_t'(i_state);

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    o_pc_write   = 1'b0;
    o_ir_write   = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_i_or_d     = 1'b0;
    o_reg_write  = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_RT;
    o_alu_op     = ALU_ADD;
    o_ext_zero   = 1'b0;
    o_pc_src     = PCSRC_ALU;
    o_illegal_op = 1'b0;

    // The extender registers its output, so its mode must be set from DECODE
    // onward and held steady until the instruction returns to FETCH.
    if (w_state != S_FETCH) begin
      o_ext_zero = is_zero_ext(i_opcode);
    end

    case (w_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        // IR load and PC+4 happen together, only once the fetch completes.
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          o_pc_src   = PCSRC_ALU;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        o_alu_src_b = SRCB_IMM_SH2;
      end
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
      end
      S_RTEXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALU_FUNCT;
      end
      S_RTWB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = (i_opcode == OP_ADDI) ? ALU_ADD : ALU_LOGIC;
      end
      S_IWB: begin
        o_reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALU_SUB;
        o_pc_src    = PCSRC_ALUOUT;
        o_pc_write  = i_alu_zero;
      end
      S_JUMP: begin
        o_pc_write = 1'b1;
        o_pc_src   = PCSRC_JUMP;
      end
      S_ILLEGAL: begin
        o_illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multi-cycle MIPS control FSM. Holds the state register, the opcode latched
// in DECODE, the next-state logic and the retired-instruction counter; the
// per-state output decode lives in mips_ctrl_decode.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   opcode          instr[31:26] from the IR, valid from DECODE onward
//   mem_ready       memory access completes in a cycle where this is high
//   alu_zero        ALU zero flag, used by beq in BRANCH
//   pc_write .. pc_src   datapath enables and mux selects
//   illegal_op      one-cycle pulse for an unrecognised opcode
//   instr_count     retired-instruction count, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             ext_zero,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_next_state;
  logic [OPC_W-1:0] r_opcode;
  logic [OPC_W-1:0] w_opcode;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_retire;

  logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_i_or_d;
  logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_src;
  logic       w_ext_zero, w_illegal_op;

  // In DECODE the latched copy is not loaded yet, so decode the live IR field.
  assign w_opcode = (r_state == S_DECODE) ? opcode : r_opcode;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                 w_next_state = S_RTEXEC;
          OP_LW, OP_SW:             w_next_state = S_MEMADR;
          OP_BEQ:                   w_next_state = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: w_next_state = S_IEXEC;
          OP_J:                     w_next_state = S_JUMP;
          default:                  w_next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: w_next_state = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next_state = S_MEMWB;
      S_MEMWR:  if (mem_ready) w_next_state = S_FETCH;
      S_RTEXEC: w_next_state = S_RTWB;
      S_IEXEC:  w_next_state = S_IWB;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // An instruction retires on its return to FETCH; FETCH stalls and the
  // ILLEGAL path do not count.
  assign w_retire = (w_next_state == S_FETCH) && (r_state != S_FETCH) &&
                    (r_state != S_ILLEGAL);

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state       <= S_FETCH;
      r_opcode      <= '0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + 1'b1;
      end
    end
  end

  mips_ctrl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .i_state      (r_state),
    .i_opcode     (w_opcode),
    .i_mem_ready  (mem_ready),
    .i_alu_zero   (alu_zero),
    .o_pc_write   (w_pc_write),
    .o_ir_write   (w_ir_write),
    .o_mem_read   (w_mem_read),
    .o_mem_write  (w_mem_write),
    .o_i_or_d     (w_i_or_d),
    .o_reg_write  (w_reg_write),
    .o_reg_dst    (w_reg_dst),
    .o_mem_to_reg (w_mem_to_reg),
    .o_alu_src_a  (w_alu_src_a),
    .o_alu_src_b  (w_alu_src_b),
    .o_alu_op     (w_alu_op),
    .o_ext_zero   (w_ext_zero),
    .o_pc_src     (w_pc_src),
    .o_illegal_op (w_illegal_op)
  );

  // Outputs are forced low while reset is asserted so an interrupted store
  // or writeback cannot fire in the reset cycle itself.
  assign pc_write    = w_pc_write   & ~reset;
  assign ir_write    = w_ir_write   & ~reset;
  assign mem_read    = w_mem_read   & ~reset;
  assign mem_write   = w_mem_write  & ~reset;
  assign i_or_d      = w_i_or_d     & ~reset;
  assign reg_write   = w_reg_write  & ~reset;
  assign reg_dst     = w_reg_dst    & ~reset;
  assign mem_to_reg  = w_mem_to_reg & ~reset;
  assign alu_src_a   = w_alu_src_a  & ~reset;
  assign alu_src_b   = reset ? 2'd0 : w_alu_src_b;
  assign alu_op      = reset ? 2'd0 : w_alu_op;
  assign ext_zero    = w_ext_zero   & ~reset;
  assign pc_src      = reset ? 2'd0 : w_pc_src;
  assign illegal_op  = w_illegal_op & ~reset;
  assign instr_count = r_instr_count;

endmodule
